program_mem: RTL and testbench
==============================

# program_mem

Program memory and loader for the program-flow datapath. Accepts a byte stream (state offset, transition offset, then program bytes) over a valid/ready handshake. On completion it switches to run mode, where it serves the flow stage's address (`out_mem`) with registered read data (`in_data`), accepts runtime data writes, and generates the even/odd `cycle` phase signal. The two offset registers drive `cfg_state_offs`/`cfg_trans_offs` of the flow stage directly.

## Interface

Parameters:
- `DEPTH` — default 256 — number of program bytes; must be 256 for the 8-bit address (kept as a parameter for reduced-size test builds, power of two, 2..256).

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset_n`  in  1  — reset; asynchronous, active-low.
- `load_valid`  in  1  — loader byte valid.
- `load_data`  in  8  — loader byte.
- `load_last`  in  1  — qualifies the final program byte.
- `load_ready`  out  1  — block accepts a byte this cycle.
- `load_err`  out  1  — sticky load-format error.
- `run`  out  1  — load complete; datapath active.
- `cycle`  out  1  — phase: 0 = EVEN, 1 = ODD.
- `cfg_state_offs`  out  8  — first loaded byte.
- `cfg_trans_offs`  out  8  — second loaded byte.
- `rd_addr`  in  8  — read address (from `out_mem`).
- `rd_data`  out  8  — registered read data (to `in_data`).
- `wr_en`  in  1  — runtime write strobe.
- `wr_addr`  in  8  — runtime write address.
- `wr_data`  in  8  — runtime write data.

## Operation

- FSM states: IDLE, LOAD_S, LOAD_T, LOAD_P, RUN, ERR. A transfer is `load_valid & load_ready`.
- IDLE: entered on reset; moves unconditionally to LOAD_S on the first clock after `reset_n` rises.
- LOAD_S: a transfer writes `cfg_state_offs`, then the FSM moves to LOAD_T.
- LOAD_T: a transfer writes `cfg_trans_offs`, then the FSM moves to LOAD_P. The 8-bit load pointer is cleared to 0.
- LOAD_P: a transfer writes `mem[ptr] <= load_data` and increments `ptr`.
  - `load_last` set: move to RUN.
  - Transfer at `ptr == DEPTH-1` without `load_last`: the byte is written, then the FSM moves to ERR.
- `load_last` asserted during a transfer in LOAD_S or LOAD_T: the byte is stored, then the FSM moves to ERR. A program needs at least 1 byte.
- `load_ready` = 1 exactly in LOAD_S, LOAD_T and LOAD_P. `load_valid` is ignored in all other states.
- RUN: terminal until reset.
  - `run` = 1.
  - `cycle` toggles every clock, starting at 0 in the first RUN cycle.
  - Reads: `rd_data <= mem[rd_addr]` every clock.
  - Writes: `wr_en` writes `mem[wr_addr] <= wr_data`.
- Read-during-write, same address, same edge: `rd_data` returns the OLD contents (read-first).
- Outside RUN: `wr_en` is ignored, `rd_data` is forced to 0, `cycle` is held at 0.
- ERR: terminal until reset.
  - `load_err` = 1, `run` = 0, `load_ready` = 0.
  - `cycle` = 0, `rd_data` = 0.
- Addresses ≥ DEPTH (reduced builds): upper address bits are ignored, so the address wraps modulo DEPTH.
- Memory array is not reset. Its contents after reset are undefined until reloaded.

## Timing

- Reset values (asserted asynchronously, held while `reset_n` = 0):
  - `load_ready` = 0, `load_err` = 0, `run` = 0, `cycle` = 0.
  - `cfg_state_offs` = 0, `cfg_trans_offs` = 0, `rd_data` = 0.
- `load_ready` rises 1 clock after `reset_n` deasserts (IDLE→LOAD_S).
- Full-rate loading: one byte per clock. Total load time for P program bytes = P + 2 transfers.
- `run` rises on the clock edge that accepts the `load_last` byte. Its first high cycle is the first RUN cycle, with `cycle` = 0.
- Read latency: 1 clock. `rd_addr` sampled at edge k produces `rd_data` valid after edge k.
  - This lines up with the flow stage: the address driven in phase A returns data in the following phase.
- A write at edge k is visible to a read sampled at edge k+1.
- Reset mid-load or mid-run:
  - All outputs return to their reset values immediately.
  - A partial program remains in the array but is not trusted.
  - A full reload is required.

## Test plan

- Reset, then stream S=0x10, T=0x20, program 0xA1,0xB2,0xC3 (last on 0xC3) at full rate → `load_ready` high for 5 cycles; `run` rises on the 0xC3 edge; `cfg_state_offs`=0x10, `cfg_trans_offs`=0x20; reads of addr 0,1,2 return 0xA1,0xB2,0xC3 one clock later.
- In RUN, observe `cycle` over 6 clocks → sequence 0,1,0,1,0,1 starting at the first RUN cycle; `run` stays 1.
- In RUN, `wr_en`=1, `wr_addr`=0x01, `wr_data`=0x5A, with `rd_addr`=0x01 on the same edge → `rd_data`=0xB2; next read of 0x01 returns 0x5A.
- `load_last` on the second (T) byte → `load_err`=1, `load_ready`=0, `run`=0 permanently; `rd_data` stays 0 for any address.
- Stream S, T, then 256 program bytes without `load_last` → all 256 written; `load_err`=1 after the 256th transfer. With toggling `load_valid` gaps, `ptr` advances only on transfers.
- Assert `reset_n`=0 mid-way through LOAD_P, release, and reload S=0x01, T=0x02, one byte 0xFF (last) → outputs reset immediately; `load_ready` high 1 clock after release; `run`=1 and addr 0 reads 0xFF.

Source files
------------

// File: rtl/program_mem.sv
//==============================================================================
// Module      : program_mem
// Description : Program memory with byte-stream loader (state offset, transition
//               offset, program bytes), run-mode read/write port, phase output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module program_mem #(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       load_err,
    output logic       run,
    output logic       cycle,
    output logic [7:0] cfg_state_offs,
    output logic [7:0] cfg_trans_offs,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data
);

    localparam int         c_addr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] c_ptr_last = 8'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_S = 3'd1,
        LOAD_T = 3'd2,
        LOAD_P = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_state_offs;
    logic [7:0]            r_trans_offs;
    logic [7:0]            r_ptr;
    logic                  r_cycle;
    logic [7:0]            r_rd_data;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_xfer;
    logic                  w_mem_we;
    logic [c_addr_w-1:0]   w_mem_waddr;
    logic [7:0]            w_mem_wdata;

    assign load_ready     = (r_state == LOAD_S) || (r_state == LOAD_T) || (r_state == LOAD_P);
    assign load_err       = (r_state == ERR);
    assign run            = (r_state == RUN);
    assign cycle          = r_cycle;
    assign cfg_state_offs = r_state_offs;
    assign cfg_trans_offs = r_trans_offs;
    assign rd_data        = r_rd_data;
    assign w_xfer         = load_valid & load_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = LOAD_S;
            LOAD_S:  if (w_xfer) w_next = load_last ? ERR : LOAD_T;
            LOAD_T:  if (w_xfer) w_next = load_last ? ERR : LOAD_P;
            LOAD_P: begin
                // load_last wins: a last byte at the final address is a valid program
                if (w_xfer) begin
                    if (load_last) begin
                        w_next = RUN;
                    end else if (r_ptr == c_ptr_last) begin
                        w_next = ERR;
                    end
                end
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_offs <= 8'h00;
            r_trans_offs <= 8'h00;
            r_ptr        <= 8'h00;
        end else if (w_xfer) begin
            if (r_state == LOAD_S) begin
                r_state_offs <= load_data;
            end
            if (r_state == LOAD_T) begin
                r_trans_offs <= load_data;
                r_ptr        <= 8'h00;
            end
            if (r_state == LOAD_P) begin
                r_ptr <= r_ptr + 8'd1;
            end
        end
    end

    // Single write port shared between the loader and run-mode writes
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_wdata = 8'h00;
        if ((r_state == LOAD_P) && w_xfer) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_ptr[c_addr_w-1:0];
            w_mem_wdata = load_data;
        end else if ((r_state == RUN) && wr_en) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = wr_addr[c_addr_w-1:0];
            w_mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Read-first: the array update above lands after this sample on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= 8'h00;
            r_cycle   <= 1'b0;
        end else if (r_state == RUN) begin
            r_rd_data <= r_mem[rd_addr[c_addr_w-1:0]];
            r_cycle   <= ~r_cycle;
        end else begin
            r_rd_data <= 8'h00;
            r_cycle   <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_mem.sv
//==============================================================================
// Module      : tb_program_mem
// Description : Directed self-checking bench for program_mem.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_program_mem;

    logic       clk;
    logic       reset_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       load_err;
    logic       run;
    logic       cycle;
    logic [7:0] cfg_state_offs;
    logic [7:0] cfg_trans_offs;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    program_mem #(.DEPTH(256)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_err       (load_err),
        .run            (run),
        .cycle          (cycle),
        .cfg_state_offs (cfg_state_offs),
        .cfg_trans_offs (cfg_trans_offs),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        wr_en      = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] stream [5];
        int ready_cnt;
        int sent;

        reset_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        rd_addr = 8'h00; wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;

        // ---- Reset values and first load ----
        #12;
        chk("rst_ready", load_ready, 0);
        chk("rst_err", load_err, 0);
        chk("rst_run", run, 0);
        chk("rst_cycle", cycle, 0);
        chk("rst_cfg_s", cfg_state_offs, 0);
        chk("rst_cfg_t", cfg_trans_offs, 0);
        chk("rst_rd", rd_data, 0);
        reset_n = 1'b1;
        #1 chk("ready_before_edge", load_ready, 0);
        tick();
        chk("ready_after_release", load_ready, 1);

        stream[0] = 8'h10; stream[1] = 8'h20; stream[2] = 8'hA1;
        stream[3] = 8'hB2; stream[4] = 8'hC3;
        ready_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = stream[i];
            load_last  = (i == 4);
            if (load_ready) ready_cnt++;
            if (i == 4) chk("run_before_last", run, 0);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("ready_cycles", ready_cnt, 5);
        chk("run_rise", run, 1);
        chk("ready_in_run", load_ready, 0);
        chk("cycle_first", cycle, 0);
        chk("cfg_s", cfg_state_offs, 8'h10);
        chk("cfg_t", cfg_trans_offs, 8'h20);

        rd_addr = 8'h00; tick();
        chk("rd0", rd_data, 8'hA1); chk("cycle1", cycle, 1);
        rd_addr = 8'h01; tick();
        chk("rd1", rd_data, 8'hB2); chk("cycle2", cycle, 0);
        rd_addr = 8'h02; tick();
        chk("rd2", rd_data, 8'hC3); chk("cycle3", cycle, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cycle_seq", cycle, 32'(i % 2));
            chk("run_hold", run, 1);
        end

        // ---- Read-during-write returns old data ----
        wr_en = 1'b1; wr_addr = 8'h01; wr_data = 8'h5A; rd_addr = 8'h01;
        tick();
        chk("rdw_old", rd_data, 8'hB2);
        wr_en = 1'b0;
        tick();
        chk("rdw_new", rd_data, 8'h5A);

        // ---- load_last on T byte -> error ----
        do_reset();
        xfer(8'h33, 1'b0);
        xfer(8'h44, 1'b1);
        chk("err_set", load_err, 1);
        chk("err_ready", load_ready, 0);
        chk("err_run", run, 0);
        chk("err_cfg_s", cfg_state_offs, 8'h33);
        chk("err_cfg_t", cfg_trans_offs, 8'h44);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 8'(i); wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'hEE;
            load_valid = 1'b1; load_last = 1'b1;
            tick();
            chk("err_rd0", rd_data, 0);
            chk("err_cycle", cycle, 0);
            chk("err_sticky", load_err, 1);
        end
        wr_en = 1'b0; load_valid = 1'b0; load_last = 1'b0;

        // ---- 256 bytes without load_last, with valid gaps ----
        do_reset();
        xfer(8'h05, 1'b0);
        xfer(8'h06, 1'b0);
        sent = 0;
        for (int k = 0; k < 600 && sent < 256; k++) begin
            load_valid = (k % 2 == 0);
            load_data  = load_valid ? (8'(sent) ^ 8'h3C) : 8'hEE;
            load_last  = 1'b0;
            if (load_valid && sent == 255) begin
                chk("ovf_err_pre", load_err, 0);
                chk("ovf_ready_pre", load_ready, 1);
            end
            tick();
            if (load_valid) sent++;
        end
        load_valid = 1'b0;
        chk("ovf_sent", sent, 256);
        chk("ovf_err", load_err, 1);
        chk("ovf_ready", load_ready, 0);
        chk("ovf_run", run, 0);

        // ---- Reset mid-load, then reload ----
        do_reset();
        xfer(8'hAA, 1'b0);
        xfer(8'hBB, 1'b0);
        xfer(8'h77, 1'b0);
        xfer(8'h88, 1'b0);
        load_valid = 1'b1; load_data = 8'h99;
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", load_ready, 0);
        chk("mid_rst_cfg_s", cfg_state_offs, 0);
        chk("mid_rst_cfg_t", cfg_trans_offs, 0);
        chk("mid_rst_err", load_err, 0);
        load_valid = 1'b0;
        tick();
        #2 reset_n = 1'b1;
        #1 chk("mid_ready_pre", load_ready, 0);
        tick();
        chk("mid_ready_post", load_ready, 1);
        xfer(8'h01, 1'b0);
        xfer(8'h02, 1'b0);
        xfer(8'hFF, 1'b1);
        chk("rel_run", run, 1);
        chk("rel_cfg_s", cfg_state_offs, 8'h01);
        chk("rel_cfg_t", cfg_trans_offs, 8'h02);
        rd_addr = 8'h00; tick(); chk("rel_rd0", rd_data, 8'hFF);
        rd_addr = 8'h01; tick(); chk("rel_rd1_partial", rd_data, 8'h88);
        rd_addr = 8'h05; tick(); chk("rel_rd5_ovf", rd_data, 8'h39);
        rd_addr = 8'hFF; tick(); chk("rel_rd255_ovf", rd_data, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
